// File: rtl/axils_wr_ch.sv
// AXI4-Lite slave write channel.
// Accepts AW and W in either order, holds one transaction, issues a single
// local register-file write, then returns the B response.
// Optional feature: define AXILS_WR_ADDR_CHECK_EN to reject addresses at or
// above REG_BYTES with DECERR, without touching the register file.
module axils_wr_ch #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_BYTES = 4096,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic              USR_WR_ENA,
  output logic [ADDR_W-1:0] USR_WR_ADDR,
  output logic [DATA_W-1:0] USR_WR_DATA,
  output logic [STRB_W-1:0] USR_WR_STB,
  input  logic              USR_WR_ACK,
  input  logic              USR_WR_ERR
);

`ifdef AXILS_WR_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW_WAIT,
    S_W_WAIT,
    S_LOCAL_WR,
    S_RESP
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic                commit;
  logic [ADDR_W-1:0]   done_addr;
  logic [STRB_W-1:0]   done_strb;
  logic                skip;
  logic                unused_prot;

  // Protection bits carry no meaning for a local register block.
  assign unused_prot = ^AWPROT;

  // Address decode check; constant false when the check is compiled out.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return CHECK_EN && (64'(a) >= 64'(REG_BYTES));
  endfunction

  // Response for a transaction that bypasses the register file.
  function automatic logic [1:0] skip_resp(input logic [ADDR_W-1:0] a);
    return addr_bad(a) ? RESP_DECERR : RESP_OKAY;
  endfunction

  assign AWREADY = ARESETn && (state == S_IDLE || state == S_AW_WAIT);
  assign WREADY  = ARESETn && (state == S_IDLE || state == S_W_WAIT);

  assign USR_WR_ADDR = {addr_q[ADDR_W-1:2], 2'b00};
  assign USR_WR_DATA = data_q;
  assign USR_WR_STB  = strb_q;

  // Detect the handshake that completes AW+W, and which address/strobe it settles on.
  always_comb begin
    commit    = 1'b0;
    done_addr = AWADDR;
    done_strb = WSTRB;
    case (state)
      S_IDLE:    commit = AWVALID && WVALID;
      S_AW_WAIT: begin
        commit    = AWVALID;
        done_strb = strb_q;
      end
      S_W_WAIT:  begin
        commit    = WVALID;
        done_addr = addr_q;
      end
      default:   commit = 1'b0;
    endcase
    skip = (done_strb == '0) || addr_bad(done_addr);
  end

  // Channel FSM: capture AW/W, drive the local write, hold the B response.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      BVALID     <= 1'b0;
      BRESP      <= RESP_OKAY;
      USR_WR_ENA <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (AWVALID) addr_q <= AWADDR;
          if (WVALID) begin
            data_q <= WDATA;
            strb_q <= WSTRB;
          end
          if (AWVALID && !WVALID)      state <= S_W_WAIT;
          else if (WVALID && !AWVALID) state <= S_AW_WAIT;
        end
        S_AW_WAIT: begin
          if (AWVALID) addr_q <= AWADDR;
        end
        S_W_WAIT: begin
          if (WVALID) begin
            data_q <= WDATA;
            strb_q <= WSTRB;
          end
        end
        S_LOCAL_WR: begin
          if (USR_WR_ACK) begin
            USR_WR_ENA <= 1'b0;
            BVALID     <= 1'b1;
            BRESP      <= USR_WR_ERR ? RESP_SLVERR : RESP_OKAY;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        if (skip) begin
          BVALID <= 1'b1;
          BRESP  <= skip_resp(done_addr);
          state  <= S_RESP;
        end else begin
          USR_WR_ENA <= 1'b1;
          state      <= S_LOCAL_WR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axils_wr_ch.sv
// Directed bench for axils_wr_ch: ordering of AW/W, error responses,
// strobe-less writes, B back-pressure, reset abort and the optional
// address check (AXILS_WR_ADDR_CHECK_EN).
module tb_axils_wr_ch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK;
  logic              ARESETn;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic              USR_WR_ENA;
  logic [ADDR_W-1:0] USR_WR_ADDR;
  logic [DATA_W-1:0] USR_WR_DATA;
  logic [STRB_W-1:0] USR_WR_STB;
  logic              USR_WR_ACK;
  logic              USR_WR_ERR;

  int total = 0;
  int bad   = 0;

  axils_wr_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_BYTES(4096)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .USR_WR_ENA(USR_WR_ENA), .USR_WR_ADDR(USR_WR_ADDR), .USR_WR_DATA(USR_WR_DATA),
    .USR_WR_STB(USR_WR_STB), .USR_WR_ACK(USR_WR_ACK), .USR_WR_ERR(USR_WR_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESETn = 1'b0; AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    USR_WR_ACK = 1'b0; USR_WR_ERR = 1'b0;

    // reset
    tick(); tick();
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_ena", USR_WR_ENA, 1'b0);
    chk("rst_addr", USR_WR_ADDR, 32'h0);
    chk("rst_data", USR_WR_DATA, 32'h0);
    ARESETn = 1'b1;
    #1;
    chk("idle_awready", AWREADY, 1'b1);
    chk("idle_wready", WREADY, 1'b1);

    // 1: AW and W together, ACK one cycle later
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_ena", USR_WR_ENA, 1'b1);
    chk("t1_addr", USR_WR_ADDR, 32'h10);
    chk("t1_data", USR_WR_DATA, 32'hDEADBEEF);
    chk("t1_stb", USR_WR_STB, 4'hF);
    chk("t1_awready_busy", AWREADY, 1'b0);
    chk("t1_wready_busy", WREADY, 1'b0);
    USR_WR_ACK = 1'b1;
    tick();
    USR_WR_ACK = 1'b0;
    chk("t1_ena_off", USR_WR_ENA, 1'b0);
    chk("t1_bvalid", BVALID, 1'b1);
    chk("t1_bresp", BRESP, 2'b00);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("t1_bvalid_clr", BVALID, 1'b0);
    chk("t1_awready_back", AWREADY, 1'b1);

    // 2: W first, AW three cycles later
    WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("t2_wready_low", WREADY, 1'b0);
    chk("t2_awready_high", AWREADY, 1'b1);
    chk("t2_ena_wait", USR_WR_ENA, 1'b0);
    tick(); tick();
    chk("t2_ena_still_off", USR_WR_ENA, 1'b0);
    AWADDR = 32'h24; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t2_ena", USR_WR_ENA, 1'b1);
    chk("t2_addr", USR_WR_ADDR, 32'h24);
    chk("t2_data", USR_WR_DATA, 32'h55);
    USR_WR_ACK = 1'b1;
    tick();
    USR_WR_ACK = 1'b0;
    chk("t2_ena_single", USR_WR_ENA, 1'b0);
    chk("t2_bvalid", BVALID, 1'b1);
    chk("t2_bresp", BRESP, 2'b00);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    // 3: AW first, W second, local error -> SLVERR
    AWADDR = 32'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t3_awready_low", AWREADY, 1'b0);
    chk("t3_wready_high", WREADY, 1'b1);
    WDATA = 32'h1234; WSTRB = 4'h3; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("t3_ena", USR_WR_ENA, 1'b1);
    chk("t3_addr", USR_WR_ADDR, 32'h08);
    chk("t3_stb", USR_WR_STB, 4'h3);
    USR_WR_ACK = 1'b1; USR_WR_ERR = 1'b1;
    tick();
    USR_WR_ACK = 1'b0; USR_WR_ERR = 1'b0;
    chk("t3_bvalid", BVALID, 1'b1);
    chk("t3_bresp", BRESP, 2'b10);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    // 4: WSTRB=0 skips the local write; BREADY already high beforehand
    BREADY = 1'b1;
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'hCAFE; WSTRB = 4'h0; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t4_no_ena", USR_WR_ENA, 1'b0);
    chk("t4_bvalid", BVALID, 1'b1);
    chk("t4_bresp", BRESP, 2'b00);
    tick();
    BREADY = 1'b0;
    chk("t4_bvalid_clr", BVALID, 1'b0);
    chk("t4_awready_back", AWREADY, 1'b1);

    // 5: B back-pressure for five cycles with a new AW/W offered
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'hA5; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    USR_WR_ACK = 1'b1; USR_WR_ERR = 1'b1;
    tick();
    USR_WR_ACK = 1'b0; USR_WR_ERR = 1'b0;
    AWADDR = 32'h30; AWVALID = 1'b1; WDATA = 32'h77; WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid_hold", BVALID, 1'b1);
      chk("t5_bresp_hold", BRESP, 2'b10);
      chk("t5_awready_blocked", AWREADY, 1'b0);
      chk("t5_wready_blocked", WREADY, 1'b0);
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t5_addr_kept", USR_WR_ADDR, 32'h14);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("t5_bvalid_clr", BVALID, 1'b0);
    chk("t5_awready_back", AWREADY, 1'b1);
    chk("t5_wready_back", WREADY, 1'b1);

    // 6: reset during LOCAL_WR aborts without a response
    AWADDR = 32'h18; AWVALID = 1'b1; WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t6_ena", USR_WR_ENA, 1'b1);
    ARESETn = 1'b0;
    tick();
    chk("t6_ena_abort", USR_WR_ENA, 1'b0);
    chk("t6_bvalid_abort", BVALID, 1'b0);
    chk("t6_awready_rst", AWREADY, 1'b0);
    chk("t6_addr_clr", USR_WR_ADDR, 32'h0);
    ARESETn = 1'b1;
    BREADY = 1'b1;
    tick(); tick();
    BREADY = 1'b0;
    chk("t6_no_b", BVALID, 1'b0);
    chk("t6_idle_awready", AWREADY, 1'b1);
    chk("t6_idle_wready", WREADY, 1'b1);

    // 7: address beyond the register space
    AWADDR = 32'h1000; AWVALID = 1'b1; WDATA = 32'h42; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
`ifdef AXILS_WR_ADDR_CHECK_EN
    chk("t7_no_ena", USR_WR_ENA, 1'b0);
    chk("t7_bvalid", BVALID, 1'b1);
    chk("t7_bresp", BRESP, 2'b11);
`else
    chk("t7_ena", USR_WR_ENA, 1'b1);
    chk("t7_addr", USR_WR_ADDR, 32'h1000);
    USR_WR_ACK = 1'b1;
    tick();
    USR_WR_ACK = 1'b0;
    chk("t7_bvalid", BVALID, 1'b1);
    chk("t7_bresp", BRESP, 2'b00);
`endif
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("t7_bvalid_clr", BVALID, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
